// File: rtl/boron_arb.sv
// boron_arb: round-robin arbiter sharing one boron_enc/boron_dec core pair between two requesters.
// Optional watchdog on the WAIT state is enabled with `define BORON_ARB_WATCHDOG_EN.
module boron_arb #(
    parameter int TEXT_W      = 64,
    parameter int KEY_W       = 80,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              mode0,
    input  logic [TEXT_W-1:0] text0,
    input  logic [KEY_W-1:0]  key0,
    output logic              ack0,
    output logic [TEXT_W-1:0] result0,
    output logic              err0,
    input  logic              req1,
    input  logic              mode1,
    input  logic [TEXT_W-1:0] text1,
    input  logic [KEY_W-1:0]  key1,
    output logic              ack1,
    output logic [TEXT_W-1:0] result1,
    output logic              err1,
    output logic              enc_start,
    output logic              dec_start,
    output logic [TEXT_W-1:0] core_text,
    output logic [KEY_W-1:0]  core_key,
    input  logic              enc_done,
    input  logic [TEXT_W-1:0] enc_result,
    input  logic              dec_done,
    input  logic [TEXT_W-1:0] dec_result
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t              state_q, state_d;
    logic                last_q, last_d, gnt_q, gnt_d, mode_q, mode_d;
    logic [TEXT_W-1:0]   text_q, text_d, res0_q, res0_d, res1_q, res1_d;
    logic [KEY_W-1:0]    key_q, key_d;
    logic                ack0_q, ack0_d, ack1_q, ack1_d;
    logic                enc_start_q, enc_start_d, dec_start_q, dec_start_d;
    logic                done, timeout, finish;
    logic [TEXT_W-1:0]   core_res;

    // Only the core that was actually started can complete the operation.
    assign done     = mode_q ? dec_done : enc_done;
    assign core_res = mode_q ? dec_result : enc_result;
    assign finish   = done || timeout;

`ifdef BORON_ARB_WATCHDOG_EN
    localparam int CNT_W = (TIMEOUT_CYC > 255) ? $clog2(TIMEOUT_CYC + 1) : 8;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err0_q, err0_d, err1_q, err1_d;

    assign timeout = (state_q == WAIT) && !done && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_comb begin
        cnt_d  = (state_q == ISSUE) ? '0 : (state_q == WAIT) ? cnt_q + 1'b1 : cnt_q;
        err0_d = timeout && !gnt_q;
        err1_d = timeout && gnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q  <= '0;
            err0_q <= 1'b0;
            err1_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            err0_q <= err0_d;
            err1_q <= err1_d;
        end
    end

    assign err0 = err0_q;
    assign err1 = err1_q;
`else
    assign timeout = 1'b0;
    assign err0    = 1'b0;
    assign err1    = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        gnt_d       = gnt_q;
        mode_d      = mode_q;
        text_d      = text_q;
        key_d       = key_q;
        res0_d      = res0_q;
        res1_d      = res1_q;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        enc_start_d = 1'b0;
        dec_start_d = 1'b0;
        case (state_q)
            IDLE: if (req0 || req1) begin
                // On contention the requester that did not win last time is served.
                gnt_d   = (req0 && req1) ? !last_q : req1;
                last_d  = gnt_d;
                mode_d  = gnt_d ? mode1 : mode0;
                text_d  = gnt_d ? text1 : text0;
                key_d   = gnt_d ? key1 : key0;
                state_d = ISSUE;
            end
            ISSUE: begin
                enc_start_d = !mode_q;
                dec_start_d = mode_q;
                state_d     = WAIT;
            end
            WAIT: if (finish) begin
                res0_d  = gnt_q ? res0_q : (done ? core_res : '0);
                res1_d  = gnt_q ? (done ? core_res : '0) : res1_q;
                ack0_d  = !gnt_q;
                ack1_d  = gnt_q;
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            gnt_q       <= 1'b0;
            mode_q      <= 1'b0;
            text_q      <= '0;
            key_q       <= '0;
            res0_q      <= '0;
            res1_q      <= '0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            enc_start_q <= 1'b0;
            dec_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            mode_q      <= mode_d;
            text_q      <= text_d;
            key_q       <= key_d;
            res0_q      <= res0_d;
            res1_q      <= res1_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            enc_start_q <= enc_start_d;
            dec_start_q <= dec_start_d;
        end
    end

    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign result0   = res0_q;
    assign result1   = res1_q;
    assign enc_start = enc_start_q;
    assign dec_start = dec_start_q;
    assign core_text = text_q;
    assign core_key  = key_q;
endmodule

// File: tb/tb_boron_arb.sv
// tb_boron_arb: directed bench for boron_arb; the bench plays both cipher cores,
// with a toy core whose result is the input block XOR a fixed pad.
module tb_boron_arb;
    localparam logic [63:0] PAD = 64'hA5A5_5A5A_F00F_0FF0;
    localparam logic [63:0] PT  = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] CT  = 64'hA486_1F3D_79A4_C21F;

    logic        clk = 1'b0, rst = 1'b0;
    logic        req0 = 1'b0, mode0 = 1'b0, req1 = 1'b0, mode1 = 1'b0;
    logic [63:0] text0 = '0, text1 = '0, enc_result = '0, dec_result = '0;
    logic [79:0] key0 = '0, key1 = '0;
    logic        enc_done = 1'b0, dec_done = 1'b0;
    logic        ack0, ack1, err0, err1, enc_start, dec_start;
    logic [63:0] result0, result1, core_text;
    logic [79:0] core_key;
    int          compared = 0, mismatched = 0;
    logic [63:0] r0, r1;

    boron_arb #(.TEXT_W(64), .KEY_W(80), .TIMEOUT_CYC(10)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .mode0(mode0), .text0(text0), .key0(key0),
        .ack0(ack0), .result0(result0), .err0(err0),
        .req1(req1), .mode1(mode1), .text1(text1), .key1(key1),
        .ack1(ack1), .result1(result1), .err1(err1),
        .enc_start(enc_start), .dec_start(dec_start),
        .core_text(core_text), .core_key(core_key),
        .enc_done(enc_done), .enc_result(enc_result),
        .dec_done(dec_done), .dec_result(dec_result)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full uncontended operation, bench acting as the selected core.
    task automatic op(input bit who, input logic m, input logic [63:0] t, input logic [79:0] k,
                      input logic [63:0] r, input string tag);
        if (who) begin req1 = 1'b1; mode1 = m; text1 = t; key1 = k; end
        else     begin req0 = 1'b1; mode0 = m; text0 = t; key0 = k; end
        tick();
        req0 = 1'b0;
        req1 = 1'b0;
        chk({tag, "_nostart"}, {enc_start, dec_start}, 2'b00);
        tick();
        chk({tag, "_start"}, {enc_start, dec_start}, m ? 2'b01 : 2'b10);
        chk({tag, "_text"}, core_text, t);
        chk({tag, "_key"}, core_key, k);
        if (m) begin dec_done = 1'b1; dec_result = r; end
        else   begin enc_done = 1'b1; enc_result = r; end
        tick();
        enc_done = 1'b0;
        dec_done = 1'b0;
        chk({tag, "_ack"}, {ack0, ack1, err0, err1}, who ? 4'b0100 : 4'b1000);
        chk({tag, "_res"}, who ? result1 : result0, r);
        tick();
        chk({tag, "_ackoff"}, {ack0, ack1, enc_start, dec_start}, 4'b0000);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_ctl", {ack0, ack1, err0, err1, enc_start, dec_start}, 6'b0);
        chk("rst_text", core_text, 64'h0);
        chk("rst_key", core_key, 80'h0);
        chk("rst_res", {result0, result1}, 128'h0);
        rst = 1'b1;

        op(1'b0, 1'b0, 64'h0, 80'h0, 64'h0000_0000_1111_2222, "single_enc");

        op(1'b0, 1'b0, PT, 80'h0, CT, "rt_enc");
        op(1'b1, 1'b1, CT, 80'h0, CT ^ PAD, "rt_dec");
        chk("rt_plain", result1, PT);
        chk("rt_res0_kept", result0, CT);

        // Contention: both held, four operations each, strictly alternating from 0.
        r0 = CT;
        r1 = PT;
        req0 = 1'b1; req1 = 1'b1; mode0 = 1'b0; mode1 = 1'b0;
        text0 = 64'hAAAA_0000_0000_0000; text1 = 64'hBBBB_0000_0000_0001;
        key0 = 80'h1; key1 = 80'h2;
        for (int i = 0; i < 8; i++) begin
            tick();
            tick();
            chk($sformatf("ct%0d_text", i), core_text, i[0] ? text1 : text0);
            chk($sformatf("ct%0d_key", i), core_key, i[0] ? 80'h2 : 80'h1);
            enc_done = 1'b1;
            enc_result = 64'h100 + 64'(i);
            tick();
            enc_done = 1'b0;
            chk($sformatf("ct%0d_ack", i), {ack0, ack1}, i[0] ? 2'b01 : 2'b10);
            chk($sformatf("ct%0d_res", i), i[0] ? result1 : result0, 64'h100 + 64'(i));
            chk($sformatf("ct%0d_other", i), i[0] ? result0 : result1, i[0] ? r0 : r1);
            if (i[0]) r1 = 64'h100 + 64'(i);
            else      r0 = 64'h100 + 64'(i);
            if (i == 6) req0 = 1'b0;
            if (i == 7) req1 = 1'b0;
            tick();
            chk($sformatf("ct%0d_ackoff", i), {ack0, ack1}, 2'b00);
        end
        tick();
        chk("ct_idle_after", {enc_start, dec_start, ack0, ack1}, 4'b0);

        // Operand change after grant and a stray done from the unselected core.
        req0 = 1'b1; mode0 = 1'b0; text0 = 64'hDEAD_BEEF_0000_0001; key0 = 80'h55;
        tick();
        req0 = 1'b0;
        text0 = 64'hFFFF_FFFF_FFFF_FFFF;
        mode0 = 1'b1;
        tick();
        chk("oc_text", core_text, 64'hDEAD_BEEF_0000_0001);
        chk("oc_start", {enc_start, dec_start}, 2'b10);
        dec_done = 1'b1;
        dec_result = 64'h1234;
        tick();
        dec_done = 1'b0;
        chk("stray_noack", {ack0, ack1}, 2'b00);
        tick();
        chk("stray_wait", {ack0, result0}, {1'b0, r0});
        enc_done = 1'b1;
        enc_result = 64'h5555_6666_7777_8888;
        tick();
        enc_done = 1'b0;
        chk("oc_ack", {ack0, result0}, {1'b1, 64'h5555_6666_7777_8888});
        tick();
        enc_done = 1'b1;
        enc_result = 64'h9;
        tick();
        enc_done = 1'b0;
        chk("idle_done_ignored", {ack0, ack1, result0}, {2'b00, 64'h5555_6666_7777_8888});

        // Reset while waiting on the decrypt core.
        req1 = 1'b1; mode1 = 1'b1; text1 = 64'h77; key1 = 80'h99;
        tick();
        req1 = 1'b0;
        tick();
        chk("rw_start", {enc_start, dec_start}, 2'b01);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("rw_ctl", {ack0, ack1, err0, err1, enc_start, dec_start}, 6'b0);
        chk("rw_data", {core_text, core_key, result0, result1}, 272'h0);
        dec_done = 1'b1;
        dec_result = 64'hABCD;
        tick();
        dec_done = 1'b0;
        chk("rw_late_done", {ack0, ack1, result1}, 66'h0);
        op(1'b0, 1'b0, 64'h42, 80'h43, 64'hC0FF_EE00_0000_0042, "after_rst");

        // Core done withheld: watchdog fires after ten WAIT cycles when built in.
        req0 = 1'b1; mode0 = 1'b0; text0 = 64'h3; key0 = 80'h4;
        tick();
        req0 = 1'b0;
        tick();
        for (int i = 0; i < 9; i++) tick();
        chk("wd_early", {ack0, err0}, 2'b00);
        tick();
`ifdef BORON_ARB_WATCHDOG_EN
        chk("wd_ack", {ack0, err0, ack1, err1}, 4'b1100);
        chk("wd_res", result0, 64'h0);
        tick();
        chk("wd_ackoff", {ack0, err0}, 2'b00);
`else
        chk("nowd_noack", {ack0, err0}, 2'b00);
        chk("nowd_res", result0, 64'hC0FF_EE00_0000_0042);
        enc_done = 1'b1;
        enc_result = 64'h7;
        tick();
        enc_done = 1'b0;
        chk("nowd_ack", {ack0, err0, result0}, {2'b10, 64'h7});
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
